// File: rtl/simple_adder_pkg.sv
// Shared widths and types for the simple adder responder.
// Default parameter values come from here so that the top and the bench agree.
package simple_adder_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SUM_W_DEF  = DATA_W_DEF + 1;
  localparam int CNT_W_DEF  = 16;

  typedef logic [SUM_W_DEF-1:0] sum_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/simple_adder_fifo.sv
// First-word fall-through result FIFO: head visible the cycle after push.
// The push side relies on upstream credits; a push into a full FIFO is dropped.
module simple_adder_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign empty     = (cnt_q == '0);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = cnt_q;

endmodule

// File: rtl/simple_adder_resp.sv
// Adder responder: sum appears PIPE_STAGES cycles after acceptance; the pipeline never stalls.
// in_ready is a credit check on registered FIFO occupancy plus in-flight stages, so results are never dropped.
module simple_adder_resp
  import simple_adder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   sum,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  carry_count
);

  localparam int SUM_W  = DATA_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = $clog2(FIFO_DEPTH + PIPE_STAGES + 1);

  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [SUM_W-1:0]       dat_q [PIPE_STAGES];
  logic [SUM_W-1:0]       dat_d [PIPE_STAGES];
  logic [CNT_W-1:0]       txn_q, txn_d;
  logic [CNT_W-1:0]       carry_q, carry_d;
  logic [FCNT_W-1:0]      fifo_count;
  logic                   fifo_empty;
  logic [SUM_W-1:0]       head_dat;
  logic [CRED_W-1:0]      inflight;
  logic                   accept;
  logic                   deliver;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      inflight = inflight + CRED_W'(vld_q[i]);
    end
  end

  // Pops this cycle are deliberately not credited until they show up in fifo_count.
  assign in_ready = !rst && ((CRED_W'(fifo_count) + inflight) < CRED_W'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign deliver  = !fifo_empty && out_ready;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    dat_d[0] = accept ? ({1'b0, a} + {1'b0, b}) : dat_q[0];
    for (int i = 1; i < PIPE_STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_comb begin
    txn_d   = txn_q;
    carry_d = carry_q;
    if (deliver) begin
      if (txn_q != '1) begin
        txn_d = txn_q + CNT_W'(1);
      end
      if (head_dat[DATA_W] && (carry_q != '1)) begin
        carry_d = carry_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      dat_q   <= '{default: '0};
      txn_q   <= '0;
      carry_q <= '0;
    end else begin
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      txn_q   <= txn_d;
      carry_q <= carry_d;
    end
  end

  simple_adder_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_q[PIPE_STAGES-1]),
    .push_data (dat_q[PIPE_STAGES-1]),
    .pop       (deliver),
    .head_data (head_dat),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign sum         = head_dat;
  assign txn_count   = txn_q;
  assign carry_count = carry_q;

endmodule

// File: doc/simple_adder_resp.md
Name: simple_adder_resp

Overview:
- Responder (DUT) end of the simple adder interface. It accepts operand pairs a/b from the driver side and returns sum = a + b with carry-out.
- Internally it has a fixed-latency pipeline feeding a small output FIFO. Credit-based input flow control means backpressure never drops a result.
- Saturating statistics counters are provided for scoreboard cross-checks.

Parameters:
- DATA_W, 8, operand width; sum is DATA_W+1 bits.
- PIPE_STAGES, 2, adder pipeline depth, legal 1..4.
- FIFO_DEPTH, 4, output FIFO entries; must be >= PIPE_STAGES, power of two.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  sole clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  responder can accept a pair this cycle.
- a  input  DATA_W  operand A.
- b  input  DATA_W  operand B.
- out_valid  output  1  result present at FIFO head.
- out_ready  input  1  consumer takes the result.
- sum  output  DATA_W+1  result; MSB is carry-out.
- txn_count  output  CNT_W  number of results delivered (output handshakes).
- carry_count  output  CNT_W  number of delivered results with sum[DATA_W]=1.

Behaviour:
- Reset (rst=1 at posedge): pipeline valids cleared, FIFO emptied, counters zeroed.
  - Outputs during and after reset: in_ready=0 while rst=1, then 1 on the first cycle after rst deasserts. out_valid=0, sum=0, txn_count=0, carry_count=0.
  - Reset mid-operation discards all in-flight and buffered results. No partial output is produced.
- Input handshake: accept when in_valid && in_ready at posedge. a/b are sampled only on acceptance.
- Arithmetic: sum = zero-extend(a) + zero-extend(b), DATA_W+1 bits, so it never overflows. Example: 8'hFF + 8'hFF = 9'h1FE.
- Pipeline:
  - Each stage has a valid bit and a data register. It advances every cycle unconditionally, with no stall.
  - Stage 1 captures the raw sum. The final stage writes into the FIFO.
- Credits:
  - inflight = number of valid pipeline stages.
  - in_ready = !rst && (fifo_count + inflight < FIFO_DEPTH). This guarantees the FIFO never overflows.
  - FIFO pops in the same cycle do not raise in_ready combinationally; in_ready is computed from registered state only.
- FIFO:
  - First-word fall-through: out_valid = !empty, and sum = head entry (sum=0 when empty).
  - Pop on out_valid && out_ready.
  - A simultaneous push and pop leaves the count unchanged, and ordering is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a pair accepted at edge N appears on out_valid/sum after edge N+PIPE_STAGES, provided the FIFO was empty. Throughput is 1 result per cycle when out_ready is held high.
- Backpressure: with out_ready=0, exactly FIFO_DEPTH pairs are accepted, then in_ready falls. in_ready returns one cycle after the first pop.
- Counters:
  - txn_count increments on each output handshake.
  - carry_count increments on each output handshake where sum[DATA_W]=1.
  - Both saturate at all-ones and do not wrap.
- out_ready asserted while out_valid=0 has no effect. in_valid with in_ready=0 is ignored, and the operands must be held by the driver.

Decomposition:
- simple_adder_pkg holds:
  - DATA_W_DEF and SUM_W_DEF.
  - the typedef sum_t (logic [SUM_W_DEF-1:0]).
  - the typedef op_pair_t, a packed struct of a and b.
  - the CNT_W_DEF constant.
- One sub-module, simple_adder_fifo:
  - parameterised by width and depth.
  - ports: push, push_data, pop, head_data, empty, count.
  - synchronous active-high reset.
- The pipeline, credit logic and counters live in the top module.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, sum=0 and counters 0 throughout. in_ready=1 in the first cycle after release.
- Single transaction: a=8'h12, b=8'h34, out_ready=1 -> sum=9'h046 exactly 2 edges after acceptance; txn_count=1, carry_count=0.
- Carry and back-to-back streaming: pairs (FF,01), (80,80), (FF,FF), (00,00) on consecutive cycles -> sums 100, 100, 1FE, 000 in order on consecutive cycles; carry_count=3.
- Backpressure: out_ready=0 while driving 6 pairs -> only 4 accepted and in_ready low after the 4th. Raising out_ready drains 4 results in order, then the remaining 2 are accepted.
- Reset mid-flight: accept 3 pairs, assert rst before any pop -> out_valid=0 after reset and no stale sums appear later. Counters read 0.
- Saturation: force CNT_W=4 and deliver 20 pairs with carry -> txn_count and carry_count stay at 4'hF.
